data_mem_ctrl: RTL and testbench

//  Byte-addressable RISC-V data memory with a req/ready/valid handshake and configurable wait states.

---
 rtl/data_mem_ctrl.sv | 162 ++++++++++++++++
 tb/tb_data_mem_ctrl.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_ctrl.sv
// Byte-addressable RISC-V data memory with req/ready/valid handshake,
// configurable wait states, sign/zero-extended loads and lane stores.
module data_mem_ctrl #(
  parameter int WIDTH       = 32,
  parameter int DEPTH_BYTES = 1024,
  parameter int LATENCY     = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req,
  input  logic             WE,
  input  logic [WIDTH-1:0] A,
  input  logic [2:0]       funct3,
  input  logic [WIDTH-1:0] in_Data,
  output logic             ready,
  output logic             o_Valid,
  output logic [WIDTH-1:0] o_Data,
  output logic             o_Misaligned
);

  localparam int AW = $clog2(DEPTH_BYTES);

  typedef enum logic {IDLE, BUSY} state_e;

  state_e           state_q, state_d;
  logic [2:0]       cnt_q, cnt_d;
  logic [AW-1:0]    addr_q;
  logic             we_q;
  logic [2:0]       f3_q;
  logic [WIDTH-1:0] wdata_q;
  logic             valid_q;
  logic [WIDTH-1:0] rdata_q;
  logic             mis_q;

  logic             accept;
  logic             done;
  logic             fault;
  logic             wr_en;
  logic [WIDTH-1:0] ld_data;
  logic [AW-1:0]    a1, a2, a3;
  logic [7:0]       b0, b1, b2, b3;

  logic [7:0] mem_q [DEPTH_BYTES];

  // Address bits above the array size wrap silently.
  logic unused_hi;
  assign unused_hi = ^A[WIDTH-1:AW];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (req) begin
          state_d = BUSY;
          cnt_d   = 3'(LATENCY - 1);
        end
      end
      BUSY: begin
        if (cnt_q == '0) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    ready  = (state_q == IDLE);
    accept = ready & req;
    done   = (state_q == BUSY) & (cnt_q == '0);
  end

  always_comb begin
    fault = 1'b1;
    unique case (f3_q)
      3'b000:  fault = 1'b0;
      3'b001:  fault = addr_q[0];
      3'b010:  fault = |addr_q[1:0];
      3'b100:  fault = we_q;
      3'b101:  fault = we_q | addr_q[0];
      default: fault = 1'b1;
    endcase
  end

  assign a1 = addr_q + AW'(1);
  assign a2 = addr_q + AW'(2);
  assign a3 = addr_q + AW'(3);
  assign b0 = mem_q[addr_q];
  assign b1 = mem_q[a1];
  assign b2 = mem_q[a2];
  assign b3 = mem_q[a3];

  always_comb begin
    ld_data = '0;
    unique case (f3_q)
      3'b000:  ld_data = {{24{b0[7]}}, b0};
      3'b001:  ld_data = {{16{b1[7]}}, b1, b0};
      3'b010:  ld_data = {b3, b2, b1, b0};
      3'b100:  ld_data = {24'd0, b0};
      3'b101:  ld_data = {16'd0, b1, b0};
      default: ld_data = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q  <= '0;
      we_q    <= 1'b0;
      f3_q    <= '0;
      wdata_q <= '0;
      valid_q <= 1'b0;
      rdata_q <= '0;
      mis_q   <= 1'b0;
    end else begin
      if (accept) begin
        addr_q  <= A[AW-1:0];
        we_q    <= WE;
        f3_q    <= funct3;
        wdata_q <= in_Data;
      end
      valid_q <= done;
      mis_q   <= done & fault;
      if (done) begin
        rdata_q <= (we_q | fault) ? '0 : ld_data;
      end
    end
  end

  // Reset forces IDLE, so an aborted access never reaches the write.
  assign wr_en = done & we_q & ~fault;

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[addr_q] <= wdata_q[7:0];
      if (f3_q[1:0] != 2'b00) begin
        mem_q[a1] <= wdata_q[15:8];
      end
      if (f3_q[1]) begin
        mem_q[a2] <= wdata_q[23:16];
        mem_q[a3] <= wdata_q[31:24];
      end
    end
  end

  assign o_Valid      = valid_q;
  assign o_Data       = rdata_q;
  assign o_Misaligned = mis_q;

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Scoreboard bench for data_mem_ctrl: LATENCY=2 main instance plus
// a LATENCY=1 instance for the held-request throughput scenario.
module tb_data_mem_ctrl;

  localparam int LAT = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req = 1'b0;
  logic        WE = 1'b0;
  logic [31:0] A = '0;
  logic [2:0]  funct3 = '0;
  logic [31:0] in_Data = '0;
  logic        ready;
  logic        o_Valid;
  logic [31:0] o_Data;
  logic        o_Misaligned;

  logic        req1 = 1'b0;
  logic        ready1;
  logic        o_Valid1;
  logic [31:0] o_Data1;
  logic        o_Misaligned1;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  typedef struct {
    logic [31:0] d;
    logic        m;
    int          due;
  } exp_t;

  exp_t sb_q[$];

  data_mem_ctrl #(.WIDTH(32), .DEPTH_BYTES(1024), .LATENCY(LAT)) u_dut (
    .clk(clk), .rst_n(rst_n), .req(req), .WE(WE), .A(A),
    .funct3(funct3), .in_Data(in_Data), .ready(ready),
    .o_Valid(o_Valid), .o_Data(o_Data), .o_Misaligned(o_Misaligned)
  );

  data_mem_ctrl #(.WIDTH(32), .DEPTH_BYTES(1024), .LATENCY(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .req(req1), .WE(1'b0), .A(32'h0),
    .funct3(3'b010), .in_Data(32'h0), .ready(ready1),
    .o_Valid(o_Valid1), .o_Data(o_Data1), .o_Misaligned(o_Misaligned1)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rst_n) begin
      if (o_Valid) begin
        if (sb_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_valid cyc=%0d data=%h", cyc, o_Data);
        end else begin
          exp_t e;
          e = sb_q.pop_front();
          checks++;
          if (o_Data !== e.d) begin
            errors++;
            $display("FAIL rsp_data got=%h exp=%h", o_Data, e.d);
          end
          checks++;
          if (o_Misaligned !== e.m) begin
            errors++;
            $display("FAIL rsp_mis got=%b exp=%b", o_Misaligned, e.m);
          end
          checks++;
          if (cyc !== e.due) begin
            errors++;
            $display("FAIL rsp_latency got=%0d exp=%0d", cyc, e.due);
          end
        end
      end else if (o_Misaligned !== 1'b0) begin
        checks++;
        errors++;
        $display("FAIL mis_outside_valid got=%b exp=0", o_Misaligned);
      end
    end
  end

  task automatic access(input logic we, input logic [31:0] a,
                        input logic [2:0] f3, input logic [31:0] d,
                        input logic [31:0] ed, input logic em);
    int n;
    exp_t e;
    n = 0;
    @(negedge clk);
    while (ready !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (ready !== 1'b1) begin
      errors++;
      $display("FAIL ready_timeout got=%b exp=1", ready);
    end
    req = 1'b1;
    WE = we;
    A = a;
    funct3 = f3;
    in_Data = d;
    e.d = ed;
    e.m = em;
    e.due = cyc + 1 + LAT;
    sb_q.push_back(e);
    @(negedge clk);
    req = 1'b0;
    checks++;
    if (ready !== 1'b0) begin
      errors++;
      $display("FAIL ready_busy got=%b exp=0", ready);
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb_q.size() != 0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout pending=%0d exp=0", sb_q.size());
      sb_q.delete();
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({ready, o_Valid, o_Misaligned} !== 3'b100) begin
      errors++;
      $display("FAIL reset_flags got=%b exp=100",
               {ready, o_Valid, o_Misaligned});
    end
    checks++;
    if (o_Data !== 32'h0) begin
      errors++;
      $display("FAIL reset_data got=%h exp=0", o_Data);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_store_load();
    access(1'b1, 32'h10, 3'b010, 32'hDEADBEEF, 32'h0, 1'b0);
    access(1'b0, 32'h10, 3'b010, 32'h0, 32'hDEADBEEF, 1'b0);
    drain();
  endtask

  task automatic test_sign_ext();
    access(1'b0, 32'h13, 3'b000, 32'h0, 32'hFFFFFFDE, 1'b0);
    access(1'b0, 32'h13, 3'b100, 32'h0, 32'h000000DE, 1'b0);
    access(1'b0, 32'h12, 3'b001, 32'h0, 32'hFFFFDEAD, 1'b0);
    access(1'b0, 32'h12, 3'b101, 32'h0, 32'h0000DEAD, 1'b0);
    access(1'b0, 32'h10, 3'b000, 32'h0, 32'hFFFFFFEF, 1'b0);
    access(1'b0, 32'h11, 3'b100, 32'h0, 32'h000000BE, 1'b0);
    drain();
  endtask

  task automatic test_partial_store();
    access(1'b1, 32'h11, 3'b000, 32'h12345678, 32'h0, 1'b0);
    access(1'b0, 32'h10, 3'b010, 32'h0, 32'hDEAD78EF, 1'b0);
    access(1'b1, 32'h12, 3'b001, 32'hAAAA5555, 32'h0, 1'b0);
    access(1'b0, 32'h10, 3'b010, 32'h0, 32'h555578EF, 1'b0);
    drain();
  endtask

  task automatic test_faults();
    access(1'b0, 32'h12, 3'b010, 32'h0, 32'h0, 1'b1);
    access(1'b1, 32'h13, 3'b001, 32'hFFFFFFFF, 32'h0, 1'b1);
    access(1'b0, 32'h10, 3'b011, 32'h0, 32'h0, 1'b1);
    access(1'b1, 32'h10, 3'b100, 32'h11111111, 32'h0, 1'b1);
    access(1'b1, 32'h10, 3'b111, 32'h22222222, 32'h0, 1'b1);
    access(1'b0, 32'h11, 3'b101, 32'h0, 32'h0, 1'b1);
    access(1'b0, 32'h10, 3'b010, 32'h0, 32'h555578EF, 1'b0);
    drain();
  endtask

  task automatic test_back_to_back();
    int nval;
    nval = 0;
    @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      req1 = 1'b1;
      checks++;
      if (ready1 !== (i % 2 == 0)) begin
        errors++;
        $display("FAIL b2b_ready i=%0d got=%b exp=%b",
                 i, ready1, (i % 2 == 0));
      end
      checks++;
      if (o_Valid1 !== (i > 0 && i % 2 == 0)) begin
        errors++;
        $display("FAIL b2b_valid i=%0d got=%b exp=%b",
                 i, o_Valid1, (i > 0 && i % 2 == 0));
      end
      if (o_Valid1 === 1'b1) nval++;
      @(negedge clk);
    end
    req1 = 1'b0;
    if (o_Valid1 === 1'b1) nval++;
    checks++;
    if (nval != 5) begin
      errors++;
      $display("FAIL b2b_count got=%0d exp=5", nval);
    end
    @(negedge clk);
    checks++;
    if ({o_Valid1, ready1} !== 2'b01) begin
      errors++;
      $display("FAIL b2b_idle got=%b exp=01", {o_Valid1, ready1});
    end
  endtask

  task automatic test_reset_abort();
    access(1'b1, 32'h20, 3'b010, 32'h11111111, 32'h0, 1'b0);
    drain();
    @(negedge clk);
    req = 1'b1;
    WE = 1'b1;
    A = 32'h20;
    funct3 = 3'b010;
    in_Data = 32'h22222222;
    @(negedge clk);
    req = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    checks++;
    if ({o_Valid, ready} !== 2'b01) begin
      errors++;
      $display("FAIL abort_state got=%b exp=01", {o_Valid, ready});
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (o_Valid !== 1'b0) begin
      errors++;
      $display("FAIL abort_valid got=%b exp=0", o_Valid);
    end
    access(1'b0, 32'h20, 3'b010, 32'h0, 32'h11111111, 1'b0);
    drain();
  endtask

  task automatic test_wrap();
    access(1'b1, 32'h404, 3'b010, 32'hCAFEF00D, 32'h0, 1'b0);
    access(1'b0, 32'h4, 3'b010, 32'h0, 32'hCAFEF00D, 1'b0);
    access(1'b0, 32'hFFFF_F806, 3'b101, 32'h0, 32'h0000CAFE, 1'b0);
    drain();
  endtask

  initial begin
    test_reset();
    test_store_load();
    test_sign_ext();
    test_partial_store();
    test_faults();
    test_back_to_back();
    test_reset_abort();
    test_wrap();
    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
